down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/counter_pkg.sv | 23 ++
 rtl/down_count_core.sv | 43 ++++
 rtl/down_timer.sv | 78 +++++++
 tb/tb_down_timer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the down_timer block: FSM encoding, default width and
// the command set the FSM issues to the count/reload datapath.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // One command per falling edge; the FSM resolves priority before issuing it.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_START,
        OP_DEC,
        OP_RELOAD,
        OP_ZERO
    } core_op_t;

endpackage

// File: rtl/down_count_core.sv
// Count and Reload registers with the decrement/reload mux; commanded by the
// down_timer FSM through a single op per falling edge.
module down_count_core
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  core_op_t         op,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic             count_is_one,
    output logic             reload_zero
);

    logic [WIDTH-1:0] reload;

    // NOTE: async active-low reset in the sensitivity list clears state without a clock edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            reload <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (op)
                OP_LOAD: begin
                    reload <= preset;
                    count  <= preset;
                end
                OP_START:  count <= reload;
                OP_DEC:    count <= count - WIDTH'(1);
                OP_RELOAD: count <= reload;
                OP_ZERO:   count <= '0;
                default:   count <= count;
            endcase
        end
    end

    assign count_is_one = (count == WIDTH'(1));
    assign reload_zero  = (reload == '0);

endmodule

// File: rtl/down_timer.sv
// Falling-edge down-counting timer with one-shot/periodic modes; the FSM and
// Borrow register live here, the count datapath in down_count_core.
module down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Load,
    input  logic             Start,
    input  logic             Enable,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Preset,
    output logic [WIDTH-1:0] Count,
    output logic             Borrow,
    output logic             Busy,
    output logic             Done
);

    state_t   state;
    state_t   next_state;
    core_op_t op;
    logic     next_borrow;
    logic     count_is_one;
    logic     reload_zero;

    down_count_core #(.WIDTH(WIDTH)) u_core (
        .clk          (Clock),
        .rst_n        (Clear),
        .op           (op),
        .preset       (Preset),
        .count        (Count),
        .count_is_one (count_is_one),
        .reload_zero  (reload_zero)
    );

    // Priority: Load, then a valid Start, then counting in RUN.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        op          = OP_HOLD;
        next_state  = state;
        next_borrow = 1'b0;
        if (!Load) begin
            op         = OP_LOAD;
            next_state = IDLE;
        end else if (Start && !reload_zero) begin
            op         = OP_START;
            next_state = RUN;
        end else if (state == RUN && Enable) begin
            if (count_is_one) begin
                next_borrow = 1'b1;
                if (Mode) begin
                    op = OP_RELOAD;
                end else begin
                    op         = OP_ZERO;
                    next_state = DONE;
                end
            end else begin
                op = OP_DEC;
            end
        end
    end

    always_ff @(negedge Clock or negedge Clear) begin
        if (!Clear) begin
            state  <= IDLE;
            Borrow <= 1'b0;
        end else begin
            state  <= next_state;
            Borrow <= next_borrow;
        end
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: an arithmetic reference model compared every
// rising edge, plus hand-computed expectations at the interesting points.
module tb_down_timer;

    localparam int W = 4;

    logic         Clock  = 1'b0;
    logic         Clear  = 1'b0;
    logic         Load   = 1'b1;
    logic         Start  = 1'b0;
    logic         Enable = 1'b0;
    logic         Mode   = 1'b0;
    logic [W-1:0] Preset = '0;
    logic [W-1:0] Count;
    logic         Borrow;
    logic         Busy;
    logic         Done;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference model state: plain integers and flags.
    int m_count    = 0;
    int m_reload   = 0;
    bit m_running  = 1'b0;
    bit m_finished = 1'b0;
    bit m_borrow   = 1'b0;

    down_timer #(.WIDTH(W)) dut (
        .Clock  (Clock),
        .Clear  (Clear),
        .Load   (Load),
        .Start  (Start),
        .Enable (Enable),
        .Mode   (Mode),
        .Preset (Preset),
        .Count  (Count),
        .Borrow (Borrow),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock or negedge Clear) begin
        if (!Clear) begin
            m_count = 0; m_reload = 0; m_running = 0; m_finished = 0; m_borrow = 0;
        end else begin
            m_borrow = 0;
            if (!Load) begin
                m_reload = int'(Preset);
                m_count  = int'(Preset);
                m_running = 0; m_finished = 0;
            end else if (Start && m_reload != 0) begin
                m_count = m_reload; m_running = 1; m_finished = 0;
            end else if (m_running && Enable) begin
                if (m_count == 1) begin
                    m_borrow = 1;
                    if (Mode) m_count = m_reload;
                    else begin m_count = 0; m_running = 0; m_finished = 1; end
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
    end

    always @(posedge Clock) begin
        if (cmp_en) begin
            check("model_count",  int'(Count),  m_count);
            check("model_borrow", int'(Borrow), int'(m_borrow));
            check("model_busy",   int'(Busy),   int'(m_running));
            check("model_done",   int'(Done),   int'(m_finished));
        end
    end

    // One falling edge acts; return just after the following rising edge.
    task automatic tick();
        @(negedge Clock);
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int value, input bit mode);
        Preset = W'(value); Mode = mode; Load = 1'b0; Start = 1'b0;
        tick();
        Load = 1'b1;
    endtask

    task automatic expect_out(input string tag, input int c, input int b, input int bs, input int d);
        check({tag, "_count"},  int'(Count),  c);
        check({tag, "_borrow"}, int'(Borrow), b);
        check({tag, "_busy"},   int'(Busy),   bs);
        check({tag, "_done"},   int'(Done),   d);
    endtask

    initial begin
        #1;
        expect_out("reset", 0, 0, 0, 0);
        @(posedge Clock); #1;
        Clear = 1'b1;
        cmp_en = 1'b1;
        tick();
        expect_out("post_reset", 0, 0, 0, 0);

        // One-shot from 3.
        load(3, 1'b0);
        expect_out("os_load", 3, 0, 0, 0);
        Start = 1'b1; Enable = 1'b1;
        tick();
        expect_out("os_start", 3, 0, 1, 0);
        Start = 1'b0;
        tick(); check("os_c2", int'(Count), 2);
        tick(); check("os_c1", int'(Count), 1);
        tick(); expect_out("os_term", 0, 1, 0, 1);
        tick(); expect_out("os_after", 0, 0, 0, 1);

        // Periodic from 4: 4,3,2,1,4,... with Borrow as the count returns to 4.
        load(4, 1'b1);
        Start = 1'b1;
        tick(); check("per_start", int'(Count), 4);
        Start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            tick(); check("per_c3", int'(Count), 3);
            tick(); check("per_c2", int'(Count), 2);
            tick(); check("per_c1", int'(Count), 1);
            tick(); expect_out("per_wrap", 4, 1, 1, 0);
        end

        // Enable hold at 6, then simultaneous Load/Start at 2.
        load(7, 1'b0);
        Start = 1'b1;
        tick(); Start = 1'b0;
        tick(); check("hold_c6", int'(Count), 6);
        Enable = 1'b0;
        tick(); expect_out("hold_a", 6, 0, 1, 0);
        tick(); expect_out("hold_b", 6, 0, 1, 0);
        Enable = 1'b1;
        tick(); check("hold_resume", int'(Count), 5);
        tick(); tick(); tick();
        check("ls_pre", int'(Count), 2);
        Load = 1'b0; Start = 1'b1; Preset = W'(9);
        tick(); expect_out("ls_both", 9, 0, 0, 0);
        Load = 1'b1; Start = 1'b0;

        // Zero reload: Start ignored.
        load(0, 1'b0);
        Start = 1'b1;
        tick(); expect_out("zero_start", 0, 0, 0, 0);
        Start = 1'b0;

        // Full scale one-shot: 15 edges from start to DONE, exactly one Borrow.
        load(15, 1'b0);
        Start = 1'b1;
        tick(); check("fs_start", int'(Count), 15);
        Start = 1'b0;
        begin
            int edges = 0;
            int borrows = 0;
            while (!Done && edges < 20) begin
                tick();
                edges++;
                if (Borrow) borrows++;
            end
            tick(); if (Borrow) borrows++;
            check("fs_edges", edges, 15);
            check("fs_borrows", borrows, 1);
        end

        // Periodic with reload 1: Count pinned at 1, Borrow every enabled edge.
        load(1, 1'b1);
        Start = 1'b1;
        tick(); Start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); expect_out("r1", 1, 1, 1, 0);
        end

        // Async clear mid-RUN at 5, between edges.
        load(8, 1'b0);
        Start = 1'b1;
        tick(); Start = 1'b0;
        tick(); tick(); tick();
        check("clr_pre", int'(Count), 5);
        #2 Clear = 1'b0;
        #1 expect_out("clr_async", 0, 0, 0, 0);
        @(posedge Clock); #1;
        Clear = 1'b1; Start = 1'b1;
        tick(); expect_out("clr_start", 0, 0, 0, 0);
        Start = 1'b0;

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
